// File: rtl/baked_multi_context_config.sv
// baked_multi_context_config
// Holds NUM_CTX configuration planes for one fabric interconnect tile. Config bits
// are shifted serially into a staging register. They are then committed to a chosen
// plane. The active plane drives the switch-box config bus. The active plane can be
// switched at run time while another plane is being loaded.
//
// Ports:
//   clk, rst           fabric clock; synchronous active-high reset
//   cen, shift_in      shift enable and serial data in (one bit per cycle)
//   shift_out          staging MSB, feeds the next tile in the chain
//   cset, ctx_wr_sel   commit staging into plane[ctx_wr_sel]
//   ctx_switch, ctx_sel  make plane[ctx_sel] active
//   err_clr            clear sticky err
//   conf               contents of the active plane
//   cset_out           one-cycle pulse when conf changed source or contents
//   active_ctx         active plane index
//   load_state         00 EMPTY, 01 FILLING, 10 FULL, 11 OVERRUN
//   err                sticky protocol error
module baked_multi_context_config #(
  parameter  int unsigned CONF_W  = 1164,
  parameter  int unsigned NUM_CTX = 2,
  localparam int unsigned CTX_W   = $clog2(NUM_CTX),
  localparam int unsigned CNT_W   = $clog2(CONF_W + 2)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cen,
  input  logic              shift_in,
  output logic              shift_out,
  input  logic              cset,
  input  logic [CTX_W-1:0]  ctx_wr_sel,
  input  logic              ctx_switch,
  input  logic [CTX_W-1:0]  ctx_sel,
  input  logic              err_clr,
  output logic [CONF_W-1:0] conf,
  output logic              cset_out,
  output logic [CTX_W-1:0]  active_ctx,
  output logic [1:0]        load_state,
  output logic              err
);

  localparam logic [1:0] LS_EMPTY   = 2'b00;
  localparam logic [1:0] LS_FILLING = 2'b01;
  localparam logic [1:0] LS_FULL    = 2'b10;
  localparam logic [1:0] LS_OVERRUN = 2'b11;

  localparam logic [CNT_W-1:0] CNT_FULL    = CNT_W'(CONF_W);
  localparam logic [CNT_W-1:0] CNT_OVERRUN = CNT_W'(CONF_W + 1);
  localparam logic [CTX_W:0]   CTX_LIMIT   = (CTX_W + 1)'(NUM_CTX);

  logic [CONF_W-1:0] staging;
  logic [CONF_W-1:0] planes [NUM_CTX];
  logic [CNT_W-1:0]  count;

  logic              commit_ok;
  logic              commit_err;
  logic              switch_ok;
  logic              switch_err;
  logic [CTX_W-1:0]  active_nxt;
  logic [CNT_W-1:0]  count_nxt;
  logic [1:0]        load_nxt;
  logic              cset_out_nxt;
  logic              err_nxt;

  // Serial chain output is the staging MSB itself, so each tile adds CONF_W bits.
  assign shift_out = staging[CONF_W-1];

  // Active plane read straight from the plane registers.
  assign conf = planes[active_ctx];

  // Next-state decode for commit, switch, fill counter, pulse and error.
  always_comb begin
    commit_ok    = 1'b0;
    commit_err   = 1'b0;
    switch_ok    = 1'b0;
    switch_err   = 1'b0;
    active_nxt   = active_ctx;
    count_nxt    = count;
    load_nxt     = LS_EMPTY;
    cset_out_nxt = 1'b0;
    err_nxt      = err;

    if (cset) begin
      if (!cen && (count == CNT_FULL) && ({1'b0, ctx_wr_sel} < CTX_LIMIT)) begin
        commit_ok = 1'b1;
      end else begin
        commit_err = 1'b1;
      end
    end

    if (ctx_switch) begin
      if ({1'b0, ctx_sel} < CTX_LIMIT) begin
        switch_ok  = 1'b1;
        active_nxt = ctx_sel;
      end else begin
        switch_err = 1'b1;
      end
    end

    // A valid commit only happens with cen low, so it never races a shift.
    if (commit_ok) begin
      count_nxt = '0;
    end else if (cen && (count != CNT_OVERRUN)) begin
      count_nxt = count + CNT_W'(1);
    end

    if (count_nxt == '0) begin
      load_nxt = LS_EMPTY;
    end else if (count_nxt == CNT_FULL) begin
      load_nxt = LS_FULL;
    end else if (count_nxt == CNT_OVERRUN) begin
      load_nxt = LS_OVERRUN;
    end else begin
      load_nxt = LS_FILLING;
    end

    // One pulse per edge, whether caused by a switch, a commit to the active plane, or both.
    cset_out_nxt = switch_ok || (commit_ok && (ctx_wr_sel == active_nxt));

    // Setting the error takes priority over clearing it.
    if (commit_err || switch_err) begin
      err_nxt = 1'b1;
    end else if (err_clr) begin
      err_nxt = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      staging    <= '0;
      count      <= '0;
      active_ctx <= '0;
      load_state <= LS_EMPTY;
      cset_out   <= 1'b0;
      err        <= 1'b0;
      for (int i = 0; i < int'(NUM_CTX); i++) begin
        planes[i] <= '0;
      end
    end else begin
      if (cen) begin
        staging <= {staging[CONF_W-2:0], shift_in};
      end
      if (commit_ok) begin
        planes[ctx_wr_sel] <= staging;
      end
      count      <= count_nxt;
      active_ctx <= active_nxt;
      load_state <= load_nxt;
      cset_out   <= cset_out_nxt;
      err        <= err_nxt;
    end
  end

endmodule

// File: tb/tb_baked_multi_context_config.sv
// Directed bench for baked_multi_context_config with CONF_W=8, NUM_CTX=2.
// Expected values are queued as each step is driven and popped as outputs are sampled.
module tb_baked_multi_context_config;

  localparam int unsigned CONF_W  = 8;
  localparam int unsigned NUM_CTX = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              cen;
  logic              shift_in;
  logic              shift_out;
  logic              cset;
  logic [0:0]        ctx_wr_sel;
  logic              ctx_switch;
  logic [0:0]        ctx_sel;
  logic              err_clr;
  logic [CONF_W-1:0] conf;
  logic              cset_out;
  logic [0:0]        active_ctx;
  logic [1:0]        load_state;
  logic              err;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [31:0] exp_q [$];
  string       tag_q [$];
  logic [7:0]  model_stg;

  baked_multi_context_config #(
    .CONF_W  (CONF_W),
    .NUM_CTX (NUM_CTX)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cen        (cen),
    .shift_in   (shift_in),
    .shift_out  (shift_out),
    .cset       (cset),
    .ctx_wr_sel (ctx_wr_sel),
    .ctx_switch (ctx_switch),
    .ctx_sel    (ctx_sel),
    .err_clr    (err_clr),
    .conf       (conf),
    .cset_out   (cset_out),
    .active_ctx (active_ctx),
    .load_state (load_state),
    .err        (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string tag, input logic [31:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic check(input logic [31:0] obs);
    logic [31:0] exp_v;
    string       tag;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $error("FAIL scoreboard_empty observed=%0h expected=<none>", obs);
    end else begin
      exp_v = exp_q.pop_front();
      tag   = tag_q.pop_front();
      assert (obs === exp_v) else begin
        n_errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
    end
  endtask

  task automatic expect5(input logic [7:0] c, input logic a, input logic [1:0] l,
                         input logic e, input logic p);
    push_exp("conf", 32'(c));
    push_exp("active_ctx", 32'(a));
    push_exp("load_state", 32'(l));
    push_exp("err", 32'(e));
    push_exp("cset_out", 32'(p));
  endtask

  task automatic check5();
    check(32'(conf));
    check(32'(active_ctx));
    check(32'(load_state));
    check(32'(err));
    check(32'(cset_out));
  endtask

  // One shift cycle; checks the chain output and the fill state afterwards.
  task automatic shift_bit(input logic b, input logic [1:0] exp_ld);
    cen       = 1'b1;
    shift_in  = b;
    model_stg = {model_stg[6:0], b};
    push_exp("shift_out", 32'(model_stg[7]));
    push_exp("load_state_shift", 32'(exp_ld));
    tick();
    cen = 1'b0;
    check(32'(shift_out));
    check(32'(load_state));
  endtask

  // Shift a full byte MSB-first starting from an empty count.
  task automatic shift_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) begin
      shift_bit(v[i], (i == 0) ? 2'b10 : 2'b01);
    end
  endtask

  initial begin
    logic [8:0] pat;
    rst = 1'b1; cen = 1'b0; shift_in = 1'b0; cset = 1'b0; ctx_wr_sel = '0;
    ctx_switch = 1'b0; ctx_sel = '0; err_clr = 1'b0; model_stg = '0;
    tick();
    tick();

    // Reset state
    expect5(8'h00, 1'b0, 2'b00, 1'b0, 1'b0);
    push_exp("shift_out_rst", 32'd0);
    rst = 1'b0;
    tick();
    check5();
    check(32'(shift_out));

    // Load A5 and commit to active context 0
    shift_byte(8'hA5);
    cset = 1'b1; ctx_wr_sel = 1'b0;
    expect5(8'hA5, 1'b0, 2'b00, 1'b0, 1'b1);
    tick();
    cset = 1'b0;
    check5();
    expect5(8'hA5, 1'b0, 2'b00, 1'b0, 1'b0);
    tick();
    check5();

    // Load 3C into inactive context 1: no visible change
    shift_byte(8'h3C);
    cset = 1'b1; ctx_wr_sel = 1'b1;
    expect5(8'hA5, 1'b0, 2'b00, 1'b0, 1'b0);
    tick();
    cset = 1'b0;
    check5();

    // Switch to 1, then switch to 1 again on the next cycle: two pulses
    ctx_switch = 1'b1; ctx_sel = 1'b1;
    expect5(8'h3C, 1'b1, 2'b00, 1'b0, 1'b1);
    tick();
    check5();
    expect5(8'h3C, 1'b1, 2'b00, 1'b0, 1'b1);
    tick();
    ctx_switch = 1'b0;
    check5();
    expect5(8'h3C, 1'b1, 2'b00, 1'b0, 1'b0);
    tick();
    check5();

    // Commit FF to ctx 0 and switch to 0 on the same edge: single pulse
    shift_byte(8'hFF);
    cset = 1'b1; ctx_wr_sel = 1'b0; ctx_switch = 1'b1; ctx_sel = 1'b0;
    expect5(8'hFF, 1'b0, 2'b00, 1'b0, 1'b1);
    tick();
    cset = 1'b0; ctx_switch = 1'b0;
    check5();
    expect5(8'hFF, 1'b0, 2'b00, 1'b0, 1'b0);
    tick();
    check5();

    // Commit after only 5 bits: error, no write
    shift_bit(1'b1, 2'b01);
    shift_bit(1'b0, 2'b01);
    shift_bit(1'b1, 2'b01);
    shift_bit(1'b1, 2'b01);
    shift_bit(1'b0, 2'b01);
    cset = 1'b1; ctx_wr_sel = 1'b1;
    expect5(8'hFF, 1'b0, 2'b01, 1'b1, 1'b0);
    tick();
    check5();

    // Error set and clear in the same cycle: set wins
    err_clr = 1'b1;
    expect5(8'hFF, 1'b0, 2'b01, 1'b1, 1'b0);
    tick();
    cset = 1'b0;
    check5();
    expect5(8'hFF, 1'b0, 2'b01, 1'b0, 1'b0);
    tick();
    err_clr = 1'b0;
    check5();

    // Plane 1 still holds 3C
    ctx_switch = 1'b1; ctx_sel = 1'b1;
    expect5(8'h3C, 1'b1, 2'b01, 1'b0, 1'b1);
    tick();
    ctx_switch = 1'b0;
    check5();

    // Commit while shifting is an error; the shift itself still happens
    cen = 1'b1; shift_in = 1'b1; cset = 1'b1; ctx_wr_sel = 1'b1;
    model_stg = {model_stg[6:0], 1'b1};
    expect5(8'h3C, 1'b1, 2'b01, 1'b1, 1'b0);
    tick();
    cen = 1'b0; cset = 1'b0;
    check5();

    // Reset mid-fill with a switch request pending: no pulse
    rst = 1'b1; ctx_switch = 1'b1; ctx_sel = 1'b1;
    expect5(8'h00, 1'b0, 2'b00, 1'b0, 1'b0);
    push_exp("shift_out_rst2", 32'd0);
    tick();
    rst = 1'b0; ctx_switch = 1'b0;
    model_stg = '0;
    check5();
    check(32'(shift_out));

    // Overrun: 9 bits into an 8-bit plane, chain output follows the staging MSB
    pat = 9'b1_0110_1001;
    for (int k = 1; k <= 9; k++) begin
      shift_bit(pat[9-k], (k < 8) ? 2'b01 : ((k == 8) ? 2'b10 : 2'b11));
    end
    shift_bit(1'b1, 2'b11);
    cset = 1'b1; ctx_wr_sel = 1'b0;
    expect5(8'h00, 1'b0, 2'b11, 1'b1, 1'b0);
    tick();
    cset = 1'b0;
    check5();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
